// File: rtl/sprite_pkg.sv
// Shared geometry and types for the sprite frame ROM and its read arbiter.
// The ROM holds NUM_FRAMES animation frames of FRAME_WORDS palette indices each, stored back-to-back.
package sprite_pkg;

  localparam int unsigned FRAME_WORDS = 1152;
  localparam int unsigned NUM_FRAMES  = 4;
  localparam int unsigned DATA_W      = 2;
  localparam int unsigned PIX_W       = $clog2(FRAME_WORDS);
  localparam int unsigned FRAME_W     = $clog2(NUM_FRAMES);
  localparam int unsigned ADDR_W      = $clog2(FRAME_WORDS * NUM_FRAMES);

  typedef logic [PIX_W-1:0]   pix_addr_t;
  typedef logic [ADDR_W-1:0]  rom_addr_t;
  typedef logic [FRAME_W-1:0] frame_idx_t;
  typedef logic [DATA_W-1:0]  rom_data_t;

  // First ROM word of a frame; the largest frame base plus a legal pixel still fits in ADDR_W.
  function automatic rom_addr_t frame_base(input frame_idx_t frame);
    return rom_addr_t'(frame) * rom_addr_t'(FRAME_WORDS);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request arbiter: the search starts at ptr and wraps from NUM_REQ-1 back to 0.
// Produces a one-hot grant plus the encoded winner index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W:0] cand_s;

  // Pick the first requester at or after ptr, in modular order.
  always_comb begin
    gnt    = '0;
    winner = '0;
    valid  = 1'b0;
    cand_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand_s >= (IDX_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (IDX_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!valid && req[cand_s[IDX_W-1:0]]) begin
        valid                   = 1'b1;
        winner                  = cand_s[IDX_W-1:0];
        gnt[cand_s[IDX_W-1:0]]  = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one registered sprite frame ROM among NUM_REQ draw engines: round-robin grant,
// frame*FRAME_WORDS+pixel address forming, and a tagged response pipeline matched to ROM latency.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  frame_idx_t [NUM_REQ-1:0] frame_idx,
  input  pix_addr_t  [NUM_REQ-1:0] pix_addr,
  output logic [NUM_REQ-1:0]       gnt,
  output rom_addr_t                rom_addr,
  input  rom_data_t                rom_data,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output rom_data_t                rsp_data,
  output logic                     rsp_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   ptr_nxt_s;
  logic [IDX_W:0]     ptr_inc_s;
  logic [NUM_REQ-1:0] arb_gnt_s;
  logic [IDX_W-1:0]   winner_s;
  logic               arb_valid_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic               grant_s;
  frame_idx_t         win_frame_s;
  pix_addr_t          win_pix_s;
  logic               pix_err_s;
  rom_addr_t          addr_nxt_s;
  rom_addr_t          rom_addr_r;

  // Stage 0 lines up with rom_addr, stage ROM_LAT lines up with rom_data.
  logic [ROM_LAT:0]              vld_r;
  logic [ROM_LAT:0][NUM_REQ-1:0] id_r;
  logic [ROM_LAT:0]              err_r;

  logic [NUM_REQ-1:0] rsp_valid_s;
  rom_data_t          rsp_data_s;
  logic               rsp_err_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req    (req),
    .ptr    (ptr_r),
    .gnt    (arb_gnt_s),
    .winner (winner_s),
    .valid  (arb_valid_s)
  );

  // Grants are suppressed while reset is held so no read is issued during reset.
  always_comb begin
    gnt_s   = '0;
    grant_s = 1'b0;
    if (Reset_n) begin
      gnt_s   = arb_gnt_s;
      grant_s = arb_valid_s;
    end else begin
      gnt_s   = '0;
      grant_s = 1'b0;
    end
  end

  assign gnt = gnt_s;

  // Winner address; an out-of-range pixel falls back to the frame base and is flagged.
  always_comb begin
    win_frame_s = frame_idx[winner_s];
    win_pix_s   = pix_addr[winner_s];
    pix_err_s   = (win_pix_s >= PIX_W'(FRAME_WORDS));
    addr_nxt_s  = frame_base(win_frame_s);
    if (pix_err_s) begin
      addr_nxt_s = frame_base(win_frame_s);
    end else begin
      addr_nxt_s = frame_base(win_frame_s) + rom_addr_t'(win_pix_s);
    end
  end

  // Next pointer is one past the winner, modulo NUM_REQ.
  always_comb begin
    ptr_inc_s = {1'b0, winner_s} + (IDX_W+1)'(1);
    ptr_nxt_s = ptr_inc_s[IDX_W-1:0];
    if (ptr_inc_s >= (IDX_W+1)'(NUM_REQ)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = ptr_inc_s[IDX_W-1:0];
    end
  end

  // Pointer, address register and response tag pipeline.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ptr_r      <= '0;
      rom_addr_r <= '0;
      vld_r      <= '0;
      id_r       <= '0;
      err_r      <= '0;
    end else begin
      if (grant_s) begin
        ptr_r      <= ptr_nxt_s;
        rom_addr_r <= addr_nxt_s;
      end else begin
        ptr_r      <= ptr_r;
        rom_addr_r <= rom_addr_r;
      end
      vld_r <= {vld_r[ROM_LAT-1:0], grant_s};
      id_r  <= {id_r[ROM_LAT-1:0], gnt_s};
      err_r <= {err_r[ROM_LAT-1:0], pix_err_s & grant_s};
    end
  end

  assign rom_addr = rom_addr_r;

  // ROM data arrives on the same edge as the final tag stage, so the data path is only gated here.
  always_comb begin
    rsp_valid_s = '0;
    rsp_data_s  = '0;
    rsp_err_s   = 1'b0;
    if (vld_r[ROM_LAT]) begin
      rsp_valid_s = id_r[ROM_LAT];
      rsp_err_s   = err_r[ROM_LAT];
      if (err_r[ROM_LAT]) begin
        rsp_data_s = '0;
      end else begin
        rsp_data_s = rom_data;
      end
    end else begin
      rsp_valid_s = '0;
      rsp_data_s  = '0;
      rsp_err_s   = 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_s;
  assign rsp_data  = rsp_data_s;
  assign rsp_err   = rsp_err_s;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: ROM_LAT=1 and ROM_LAT=3 builds share the same stimulus,
// each with its own ROM model and expected-response queue.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic                 Reset_n;
  logic [1:0]           req;
  frame_idx_t [1:0]     frame_idx;
  pix_addr_t  [1:0]     pix_addr;

  logic [1:0] gnt1, gnt3, rsp_valid1, rsp_valid3;
  rom_addr_t  rom_addr1, rom_addr3;
  rom_data_t  rom_data1, rom_data3, rsp_data1, rsp_data3;
  logic       rsp_err1, rsp_err3;
  rom_data_t  rd3a, rd3b;

  sprite_rom_arbiter #(.NUM_REQ(2), .ROM_LAT(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .frame_idx(frame_idx), .pix_addr(pix_addr),
    .gnt(gnt1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_err(rsp_err1));

  sprite_rom_arbiter #(.NUM_REQ(2), .ROM_LAT(3)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .frame_idx(frame_idx), .pix_addr(pix_addr),
    .gnt(gnt3), .rom_addr(rom_addr3), .rom_data(rom_data3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_err(rsp_err3));

  function automatic rom_data_t rom_f(input rom_addr_t a);
    return a[1:0] ^ a[6:5] ^ {1'b0, a[10]};
  endfunction

  // Registered ROM models with 1 and 3 cycles of latency.
  always @(posedge Clk) begin
    rom_data1 <= rom_f(rom_addr1);
    rd3a      <= rom_f(rom_addr3);
    rd3b      <= rd3a;
    rom_data3 <= rd3b;
  end

  typedef struct {
    logic [1:0] id;
    rom_data_t  data;
    logic       err;
    int         due;
  } rsp_t;

  rsp_t q1[$];
  rsp_t q3[$];
  int checks = 0;
  int errors = 0;
  int cnt = 0;
  logic      prev_g = 1'b0;
  rom_addr_t prev_a = '0;

  always @(posedge Clk) cnt <= cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cnt);
    end
  endtask

  task automatic cmp(input string nm, input logic [1:0] v, input rom_data_t d, input logic e,
                     input int qs, input rsp_t f, output logic pop);
    pop = 1'b0;
    checks++;
    if (v != 2'b00 || (qs > 0 && f.due == cnt)) begin
      if (qs == 0) begin
        errors++;
        $display("FAIL %s: unexpected rsp_valid=%b at cycle %0d", nm, v, cnt);
      end else begin
        pop = 1'b1;
        if (v !== f.id || d !== f.data || e !== f.err || f.due != cnt) begin
          errors++;
          $display("FAIL %s: got valid=%b data=%0d err=%b cycle=%0d expected valid=%b data=%0d err=%b cycle=%0d",
                   nm, v, d, e, cnt, f.id, f.data, f.err, f.due);
        end
      end
    end else if (d !== 2'd0 || e !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got data=%0d err=%b expected 0/0 at cycle %0d", nm, d, e, cnt);
    end
  endtask

  // Monitor: pops the scoreboards whenever a response is presented or due.
  always @(negedge Clk) begin
    rsp_t f1, f3;
    logic p1, p3;
    f1 = '{default: 0};
    f3 = '{default: 0};
    if (q1.size() > 0) f1 = q1[0];
    if (q3.size() > 0) f3 = q3[0];
    cmp("rsp_lat1", rsp_valid1, rsp_data1, rsp_err1, q1.size(), f1, p1);
    cmp("rsp_lat3", rsp_valid3, rsp_data3, rsp_err3, q3.size(), f3, p3);
    if (p1) void'(q1.pop_front());
    if (p3) void'(q3.pop_front());
  end

  // One bus cycle: drive inputs, check grant, push the expected response.
  task automatic cyc(input logic [1:0] r, input frame_idx_t f0, input pix_addr_t p0,
                     input frame_idx_t f1, input pix_addr_t p1,
                     input logic [1:0] eg, input rom_addr_t ea, input logic ee);
    rsp_t e;
    if (prev_g) begin
      chk("rom_addr_lat1", 32'(rom_addr1), 32'(prev_a));
      chk("rom_addr_lat3", 32'(rom_addr3), 32'(prev_a));
    end
    req = r;
    frame_idx[0] = f0; pix_addr[0] = p0;
    frame_idx[1] = f1; pix_addr[1] = p1;
    @(negedge Clk);
    chk("gnt_lat1", 32'(gnt1), 32'(eg));
    chk("gnt_lat3", 32'(gnt3), 32'(eg));
    if (eg != 2'b00) begin
      e.id   = eg;
      e.err  = ee;
      e.data = ee ? 2'd0 : rom_f(ea);
      e.due  = cnt + 2;
      q1.push_back(e);
      e.due  = cnt + 4;
      q3.push_back(e);
    end
    prev_g = (eg != 2'b00);
    prev_a = ea;
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 2'd0, 11'd0, 2'd0, 11'd0, 2'b00, 13'd0, 1'b0);
  endtask

  initial begin
    Reset_n = 1'b0;
    req = 2'b11;
    frame_idx[0] = 2'd1; pix_addr[0] = 11'd7;
    frame_idx[1] = 2'd2; pix_addr[1] = 11'd9;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("reset_gnt_lat1", 32'(gnt1), 32'd0);
      chk("reset_gnt_lat3", 32'(gnt3), 32'd0);
      @(posedge Clk); #1;
    end
    Reset_n = 1'b1;
    chk("reset_rom_addr_lat1", 32'(rom_addr1), 32'd0);
    chk("reset_rom_addr_lat3", 32'(rom_addr3), 32'd0);

    // Both requesting: strict alternation starting at requester 0.
    cyc(2'b11, 2'd1, 11'd3,  2'd3, 11'd9,  2'b01, 13'd1155, 1'b0);
    cyc(2'b11, 2'd1, 11'd3,  2'd3, 11'd9,  2'b10, 13'd3465, 1'b0);
    cyc(2'b11, 2'd1, 11'd19, 2'd3, 11'd9,  2'b01, 13'd1171, 1'b0);
    cyc(2'b11, 2'd1, 11'd19, 2'd3, 11'd25, 2'b10, 13'd3481, 1'b0);
    cyc(2'b11, 2'd1, 11'd35, 2'd3, 11'd25, 2'b01, 13'd1187, 1'b0);
    cyc(2'b11, 2'd1, 11'd35, 2'd3, 11'd41, 2'b10, 13'd3497, 1'b0);
    idle(2);

    // Single read, frame 2 pixel 5.
    cyc(2'b01, 2'd2, 11'd5, 2'd0, 11'd0, 2'b01, 13'd2309, 1'b0);
    idle(3);

    // Out-of-range pixel on requester 1.
    cyc(2'b10, 2'd0, 11'd0, 2'd1, 11'd1152, 2'b10, 13'd1152, 1'b1);
    idle(2);

    // Back-to-back grants to a lone requester, frame 0 boundaries.
    cyc(2'b01, 2'd0, 11'd0,    2'd0, 11'd0, 2'b01, 13'd0,    1'b0);
    cyc(2'b01, 2'd0, 11'd1151, 2'd0, 11'd0, 2'b01, 13'd1151, 1'b0);
    // Pointer holds across an idle cycle, so requester 1 wins next.
    idle(1);
    cyc(2'b11, 2'd2, 11'd7, 2'd1, 11'd100, 2'b10, 13'd1252, 1'b0);
    cyc(2'b01, 2'd2, 11'd7, 2'd1, 11'd100, 2'b01, 13'd2311, 1'b0);
    idle(3);

    // Reset with two reads in flight; pointer was left at requester 1.
    cyc(2'b10, 2'd0, 11'd0, 2'd3, 11'd0, 2'b10, 13'd3456, 1'b0);
    cyc(2'b01, 2'd1, 11'd2, 2'd0, 11'd0, 2'b01, 13'd1154, 1'b0);
    chk("rom_addr_prerst_lat1", 32'(rom_addr1), 32'(prev_a));
    Reset_n = 1'b0;
    req = 2'b00;
    @(negedge Clk);
    chk("midrst_gnt_lat1", 32'(gnt1), 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    q1.delete();
    q3.delete();
    prev_g = 1'b0;
    chk("midrst_rom_addr_lat1", 32'(rom_addr1), 32'd0);
    chk("midrst_rom_addr_lat3", 32'(rom_addr3), 32'd0);
    idle(4);
    cyc(2'b11, 2'd0, 11'd9, 2'd2, 11'd9, 2'b01, 13'd9,    1'b0);
    cyc(2'b10, 2'd0, 11'd9, 2'd2, 11'd9, 2'b10, 13'd2313, 1'b0);
    idle(2);

    // Highest legal address.
    cyc(2'b01, 2'd3, 11'd1151, 2'd0, 11'd0, 2'b01, 13'd4607, 1'b0);
    idle(6);

    chk("leftover_q_lat1", 32'(q1.size()), 32'd0);
    chk("leftover_q_lat3", 32'(q3.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
